// File: rtl/ysyx_22050133_lsu_stage.sv
// Memory stage between EX and WB: one dmem request per load/store, store alignment, load extraction.
// Optional build macro YSYX_22050133_LSU_MISALIGN_EN traps misaligned ld/st and adds out_misalign.
module ysyx_22050133_lsu_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_memop,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [63:0]       in_result,
   input  logic [63:0]       in_wdata,
   input  logic [4:0]        in_rd,
   input  logic              in_wen,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_wen,
   output logic [63:0]       dmem_wdata,
   output logic [7:0]        dmem_wmask,
   input  logic              dmem_resp_valid,
   input  logic [63:0]       dmem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic [4:0]        out_rd,
   output logic              out_wen,
`ifdef YSYX_22050133_LSU_MISALIGN_EN
   output logic              out_misalign,
`endif
   output logic [63:0]       fwd_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t            state_reg, state_next;
   logic              is_store_reg;
   logic [1:0]        size_reg;
   logic              unsigned_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [63:0]       wdata_reg;
   logic              wen_reg;
   logic [4:0]        out_rd_reg;
   logic [63:0]       out_data_reg, out_data_next;
   logic              out_wen_reg, out_wen_next;

   logic              accept;
   logic              in_is_mem;
   logic              misalign_in;
   logic              req_active;
   logic [5:0]        byte_shift;
   logic [63:0]       rdata_shifted;
   logic [63:0]       load_value;
   logic [7:0]        size_mask;

   assign in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   // memop 11 is reserved and behaves like a plain ALU op
   assign in_is_mem = (in_memop == 2'b01) | (in_memop == 2'b10);

`ifdef YSYX_22050133_LSU_MISALIGN_EN
   logic mis_reg;

   always_comb begin
      misalign_in = 1'b0;
      case (in_size)
         2'd0:    misalign_in = 1'b0;
         2'd1:    misalign_in = in_result[0];
         2'd2:    misalign_in = |in_result[1:0];
         default: misalign_in = |in_result[2:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mis_reg <= 1'b0;
      end else if (accept) begin
         mis_reg <= in_is_mem & misalign_in;
      end
   end

   assign out_misalign = mis_reg & (state_reg == DONE);
`else
   assign misalign_in = 1'b0;
`endif

   // Load data: bring the addressed byte lane down to bit 0, then extend by size.
   assign byte_shift    = {addr_reg[2:0], 3'b000};
   assign rdata_shifted = dmem_rdata >> byte_shift;

   always_comb begin
      load_value = rdata_shifted;
      case (size_reg)
         2'd0:    load_value = {{56{~unsigned_reg & rdata_shifted[7]}},  rdata_shifted[7:0]};
         2'd1:    load_value = {{48{~unsigned_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
         2'd2:    load_value = {{32{~unsigned_reg & rdata_shifted[31]}}, rdata_shifted[31:0]};
         default: load_value = rdata_shifted;
      endcase
   end

   always_comb begin
      size_mask = 8'hFF;
      case (size_reg)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Bytes shifted past lane 7 simply fall off: no split access across lines.
   assign req_active     = (state_reg == REQ);
   assign dmem_req_valid = req_active;
   assign dmem_addr      = req_active ? {addr_reg[ADDR_W-1:3], 3'b000} : '0;
   assign dmem_wen       = req_active & is_store_reg;
   assign dmem_wdata     = req_active ? (wdata_reg << byte_shift) : 64'd0;
   assign dmem_wmask     = req_active ? (size_mask << addr_reg[2:0]) : 8'd0;

   always_comb begin
      state_next    = state_reg;
      out_data_next = out_data_reg;
      out_wen_next  = out_wen_reg;
      case (state_reg)
         REQ: begin
            if (dmem_req_ready) state_next = WAIT;
         end
         WAIT: begin
            if (dmem_resp_valid) begin
               state_next    = DONE;
               out_data_next = is_store_reg ? 64'd0 : load_value;
               out_wen_next  = ~is_store_reg & wen_reg;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: ;
      endcase
      // Accept only happens in IDLE or a draining DONE, so it overrides the above.
      if (accept) begin
         if (!in_is_mem || misalign_in) begin
            state_next    = DONE;
            out_data_next = in_result;
            out_wen_next  = in_wen & ~in_is_mem;
         end else begin
            state_next = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         is_store_reg <= 1'b0;
         size_reg     <= 2'd0;
         unsigned_reg <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= 64'd0;
         wen_reg      <= 1'b0;
         out_rd_reg   <= 5'd0;
         out_data_reg <= 64'd0;
         out_wen_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         out_data_reg <= out_data_next;
         out_wen_reg  <= out_wen_next;
         if (accept) begin
            is_store_reg <= (in_memop == 2'b10);
            size_reg     <= in_size;
            unsigned_reg <= in_unsigned;
            addr_reg     <= in_result[ADDR_W-1:0];
            wdata_reg    <= in_wdata;
            wen_reg      <= in_wen;
            out_rd_reg   <= in_rd;
         end
      end
   end

   assign out_valid = (state_reg == DONE);
   assign out_data  = out_data_reg;
   assign fwd_data  = out_data_reg;
   assign out_rd    = out_rd_reg;
   assign out_wen   = out_wen_reg;

endmodule

// File: tb/tb_ysyx_22050133_lsu_stage.sv
// Bench for ysyx_22050133_lsu_stage: directed cases plus random ld/st/ALU ops checked against
// a byte-addressed memory model.
module tb_ysyx_22050133_lsu_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_memop;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [63:0] in_result;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_resp_valid;
   logic [63:0] dmem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic [63:0] fwd_data;
`ifdef YSYX_22050133_LSU_MISALIGN_EN
   logic        out_misalign;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  mem_b [0:255];
   logic [63:0] last_out;
   logic [63:0] last_wdata;
   logic [7:0]  last_mask;
   logic [31:0] last_addr;

   always #5 clk = ~clk;

   ysyx_22050133_lsu_stage #(.ADDR_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_memop        (in_memop),
      .in_size         (in_size),
      .in_unsigned     (in_unsigned),
      .in_result       (in_result),
      .in_wdata        (in_wdata),
      .in_rd           (in_rd),
      .in_wen          (in_wen),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_addr       (dmem_addr),
      .dmem_wen        (dmem_wen),
      .dmem_wdata      (dmem_wdata),
      .dmem_wmask      (dmem_wmask),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_rdata      (dmem_rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_rd          (out_rd),
      .out_wen         (out_wen),
`ifdef YSYX_22050133_LSU_MISALIGN_EN
      .out_misalign    (out_misalign),
`endif
      .fwd_data        (fwd_data)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] line_of(input logic [31:0] a);
      logic [63:0] v;
      int base;
      base = int'(a[7:3]) * 8;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = mem_b[base + i];
      return v;
   endfunction

   // Bytes a..a+n-1 that stay inside the 8-byte line, little endian, then extended.
   function automatic logic [63:0] ref_load(input logic [31:0] a, input logic [1:0] size,
                                            input logic uns);
      logic [63:0] v;
      int off, n, base;
      off  = int'(a[2:0]);
      n    = 1 << size;
      base = int'(a[7:3]) * 8;
      v    = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) v[8*i +: 8] = mem_b[base + off + i];
      if (!uns && n < 8 && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic present(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                          input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd,
                          input logic wen);
      in_valid    = 1'b1;
      in_memop    = memop;
      in_size     = size;
      in_unsigned = uns;
      in_result   = res;
      in_wdata    = wd;
      in_rd       = rd;
      in_wen      = wen;
   endtask

   // Called at the negedge after the ld/st was accepted; returns at the negedge in DONE.
   task automatic mem_phase(input logic st, input logic [31:0] a, input logic [1:0] size,
                            input logic [63:0] wd, input int rq_dly, input int rs_dly);
      logic [7:0]  emask;
      logic [63:0] edata, bm;
      int off, n, base;
      off   = int'(a[2:0]);
      n     = 1 << size;
      base  = int'(a[7:3]) * 8;
      emask = '0;
      edata = '0;
      bm    = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) begin
            emask[off+i]         = 1'b1;
            edata[8*(off+i) +: 8] = wd[8*i +: 8];
            bm[8*(off+i) +: 8]    = 8'hFF;
         end
      for (int k = 0; k <= rq_dly; k++) begin
         chk("req_valid", dmem_req_valid, 1);
         chk("req_addr", dmem_addr, {a[31:3], 3'b000});
         chk("req_wen", dmem_wen, st);
         chk("req_wmask", dmem_wmask, emask);
         if (st) chk("req_wdata", dmem_wdata & bm, edata);
         chk("busy_out_valid", out_valid, 0);
         last_mask       = dmem_wmask;
         last_wdata      = dmem_wdata;
         last_addr       = dmem_addr;
         dmem_req_ready  = (k == rq_dly);
         dmem_resp_valid = (k < rq_dly) ? 1'($urandom) : 1'b0;
         dmem_rdata      = {$urandom, $urandom};
         step();
      end
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      chk("req_drop", dmem_req_valid, 0);
      if (st)
         for (int i = 0; i < 8; i++)
            if (emask[i]) mem_b[base + i] = edata[8*i +: 8];
      for (int k = 0; k < rs_dly; k++) begin
         dmem_req_ready = 1'($urandom);
         step();
         chk("wait_hold", out_valid, 0);
      end
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_rdata      = line_of(a);
      step();
      dmem_resp_valid = 1'b0;
      dmem_rdata      = {$urandom, $urandom};
   endtask

   // One complete operation from IDLE back to IDLE; starts and ends at a negedge.
   task automatic do_op(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                        input logic [63:0] res, input logic [63:0] wd, input logic [4:0] rd,
                        input logic wen, input int rq_dly, input int rs_dly, input int or_dly);
      logic        is_mem, st, exp_wen;
      logic [63:0] exp_data;
      is_mem   = (memop == 2'b01) || (memop == 2'b10);
      st       = (memop == 2'b10);
      exp_data = !is_mem ? res : (st ? 64'd0 : ref_load(res[31:0], size, uns));
      exp_wen  = st ? 1'b0 : wen;
      chk("in_ready_idle", in_ready, 1);
      present(memop, size, uns, res, wd, rd, wen);
      step();
      in_valid  = 1'b0;
      out_ready = (or_dly == 0);
      if (is_mem) mem_phase(st, res[31:0], size, wd, rq_dly, rs_dly);
      else        chk("no_req", dmem_req_valid, 0);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_data);
      chk("fwd_data", fwd_data, exp_data);
      chk("out_rd", out_rd, rd);
      chk("out_wen", out_wen, exp_wen);
      last_out = out_data;
      for (int k = 0; k < or_dly; k++) begin
         step();
         chk("stall_valid", out_valid, 1);
         chk("stall_data", out_data, exp_data);
         chk("stall_rd", out_rd, rd);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      chk("out_drop", out_valid, 0);
      $display("txn op=%0d size=%0d uns=%0d res=%h rd=%0d data=%h", memop, size, uns, res, rd,
               exp_data);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  memop, size;
      logic [31:0] addr;
      logic [63:0] res, e1, e2;
      int          off;

      rst = 1'b1;
      in_valid = 1'b0; in_memop = '0; in_size = '0; in_unsigned = 1'b0;
      in_result = '0; in_wdata = '0; in_rd = '0; in_wen = 1'b0;
      dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_rdata = '0; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", dmem_req_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_dmem_addr", dmem_addr, 0);
      chk("rst_out_wen", out_wen, 0);
      rst = 1'b0;

      // ALU passthrough
      do_op(2'b00, 2'd0, 1'b0, 64'h1234, 64'h0, 5'd5, 1'b1, 0, 0, 0);
      chk("alu_value", last_out, 64'h1234);

      // lb / lbu from byte 3 of line 0x80000000 = 0x00000000_80FF0000
      for (int i = 0; i < 8; i++) mem_b[i] = 8'h00;
      mem_b[2] = 8'hFF;
      mem_b[3] = 8'h80;
      do_op(2'b01, 2'd0, 1'b0, 64'h80000003, 64'h0, 5'd6, 1'b1, 0, 0, 0);
      chk("lb_value", last_out, 64'hFFFFFFFFFFFFFF80);
      do_op(2'b01, 2'd0, 1'b1, 64'h80000003, 64'h0, 5'd6, 1'b1, 1, 1, 0);
      chk("lbu_value", last_out, 64'h80);

      // sh at byte 6
      do_op(2'b10, 2'd1, 1'b0, 64'h80000006, 64'hBEEF, 5'd3, 1'b1, 0, 0, 0);
      chk("sh_addr", last_addr, 64'h80000000);
      chk("sh_mask", last_mask, 64'hC0);
      chk("sh_wdata", last_wdata, 64'hBEEF000000000000);

      // req_ready held off 3 cycles, out_ready held off 2 cycles
      do_op(2'b01, 2'd2, 1'b0, 64'h80000010, 64'h0, 5'd9, 1'b1, 3, 1, 2);

      // back-to-back loads
      e1 = ref_load(32'h80000000, 2'd3, 1'b0);
      e2 = ref_load(32'h80000008, 2'd3, 1'b0);
      present(2'b01, 2'd3, 1'b0, 64'h80000000, 64'h0, 5'd7, 1'b1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mem_phase(1'b0, 32'h80000000, 2'd3, 64'h0, 0, 0);
      chk("b2b_first_valid", out_valid, 1);
      chk("b2b_first_data", out_data, e1);
      present(2'b01, 2'd3, 1'b0, 64'h80000008, 64'h0, 5'd8, 1'b1);
      chk("b2b_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      mem_phase(1'b0, 32'h80000008, 2'd3, 64'h0, 0, 0);
      chk("b2b_second_data", out_data, e2);
      chk("b2b_second_rd", out_rd, 8);
      step();
      chk("b2b_drop", out_valid, 0);
      $display("txn back-to-back ld data=%h,%h", e1, e2);

      // reset while waiting for the response; late response must be ignored
      present(2'b01, 2'd3, 1'b0, 64'h80000010, 64'h0, 5'd4, 1'b1);
      step();
      in_valid = 1'b0;
      chk("rstop_req", dmem_req_valid, 1);
      dmem_req_ready = 1'b1;
      step();
      dmem_req_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstop_req_drop", dmem_req_valid, 0);
      dmem_resp_valid = 1'b1;
      dmem_rdata      = line_of(32'h80000010);
      step();
      dmem_resp_valid = 1'b0;
      chk("rstop_out_valid", out_valid, 0);
      chk("rstop_in_ready", in_ready, 1);
      step();
      chk("rstop_out_valid2", out_valid, 0);
      $display("txn reset during WAIT");

`ifdef YSYX_22050133_LSU_MISALIGN_EN
      present(2'b01, 2'd2, 1'b0, 64'h2, 64'h0, 5'd10, 1'b1);
      step();
      in_valid = 1'b0;
      chk("mis_no_req", dmem_req_valid, 0);
      chk("mis_valid", out_valid, 1);
      chk("mis_flag", out_misalign, 1);
      chk("mis_data", out_data, 64'h2);
      chk("mis_wen", out_wen, 0);
      step();
      chk("mis_drop", out_valid, 0);
      $display("txn misaligned lw addr=2");
`endif

      for (int t = 0; t < 200; t++) begin
         memop = 2'($urandom_range(0, 3));
         size  = 2'($urandom_range(0, 3));
         off   = $urandom_range(0, 7);
`ifdef YSYX_22050133_LSU_MISALIGN_EN
         off   = off & ~((1 << size) - 1);
`endif
         addr  = {24'h800000, 5'($urandom_range(0, 31)), 3'(off)};
         res   = (memop == 2'b01 || memop == 2'b10) ? {$urandom, addr} : {$urandom, $urandom};
         do_op(memop, size, 1'($urandom), res, {$urandom, $urandom}, 5'($urandom),
               1'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
